// File: rtl/div_unit.sv
// Signed 32-bit restoring divider with MIPS DIV semantics.
// One quotient bit per cycle; HI gets the remainder, LO the quotient.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_end,
  output logic        div_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_ZERO
  } state_t;

  state_t      r_state;
  logic [31:0] r_dvd;
  logic [31:0] r_dsr;
  logic [31:0] r_rem;
  logic [5:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;

  assign w_abs_a = a[31] ? (~a + 32'd1) : a;
  assign w_abs_b = b[31] ? (~b + 32'd1) : b;

  // rem < divisor <= 2^31, so the shifted value fits and bit 32 is the sign
  assign w_shift = {r_rem, r_dvd[31]};
  assign w_diff  = w_shift - {1'b0, r_dsr};
  assign w_ge    = ~w_diff[32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_end  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
    end else begin
      div_end  <= 1'b0;
      div_zero <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (div_start) begin
            busy <= 1'b1;
            if (b == 32'd0) begin
              r_state <= S_ZERO;
            end else begin
              r_dvd   <= w_abs_a;
              r_dsr   <= w_abs_b;
              r_rem   <= '0;
              r_neg_q <= a[31] ^ b[31];
              r_neg_r <= a[31];
              r_cnt   <= '0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
          r_dvd <= {r_dvd[30:0], w_ge};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31)
            r_state <= S_FIX;
        end
        S_FIX: begin
          lo      <= r_neg_q ? (~r_dvd + 32'd1) : r_dvd;
          hi      <= r_neg_r ? (~r_rem + 32'd1) : r_rem;
          div_end <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ZERO: begin
          div_end  <= 1'b1;
          div_zero <= 1'b1;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus
// hand sequences for busy-ignore, reset abort and back-to-back.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        div_start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_end;
  logic        div_zero;
  logic        busy;

  int total;
  int bad;

  div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .div_start(div_start),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .div_end  (div_end),
    .div_zero (div_zero),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept on the next edge, then wait for div_end with a cycle bound.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] elo, input logic [31:0] ehi,
                        input logic ez);
    int k;
    int lat;
    lat = ez ? 1 : 33;
    @(negedge clk);
    div_start = 1'b1;
    a = ia;
    b = ib;
    @(posedge clk);
    #1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("end_low_at_accept", {31'd0, div_end}, 32'd0);
    @(negedge clk);
    div_start = 1'b0;
    a = 32'hDEADBEEF;
    b = 32'h0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (div_end) begin
        k = i;
        break;
      end
    end
    chk("latency", k, lat);
    chk("lo", lo, elo);
    chk("hi", hi, ehi);
    chk("div_zero", {31'd0, div_zero}, {31'd0, ez});
    chk("busy_at_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_pulse_gone;
    @(posedge clk);
    #1;
    chk("end_one_cycle", {31'd0, div_end}, 32'd0);
    chk("zero_one_cycle", {31'd0, div_zero}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k;
    total = 0;
    bad = 0;
    div_start = 1'b0;
    a = '0;
    b = '0;

    vecs[0]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
    vecs[3]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{32'd5,        32'd0,        32'd3,        32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    vecs[6]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0};
    vecs[9]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
    vecs[10] = '{32'd12345678, 32'd12345,    32'd1000,     32'd678,      1'b0};
    vecs[11] = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0};

    reset = 1'b1;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_end", {31'd0, div_end}, 32'd0);
    chk("rst_zero", {31'd0, div_zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].zero);
      chk_pulse_gone();
    end

    // Start while busy must be ignored
    @(negedge clk);
    div_start = 1'b1;
    a = 32'd100;
    b = 32'd7;
    @(posedge clk);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      div_start = (i == 10);
      a = (i == 10) ? 32'd1 : 32'd0;
      b = (i == 10) ? 32'd1 : 32'd0;
      @(posedge clk);
      #1;
      if (div_end) begin
        k = i;
        break;
      end
    end
    chk("ign_latency", k, 33);
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);
    chk_pulse_gone();

    // Reset mid-calculation aborts the operation
    @(negedge clk);
    div_start = 1'b1;
    a = 32'd100;
    b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    div_start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (div_end) k++;
    end
    chk("abort_no_end", k, 0);
    run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Back-to-back: next start accepted right after the FIX edge
    run_op(32'd20, 32'd6, 32'd3, 32'd2, 1'b0);
    run_op(32'd5, 32'd0, 32'd3, 32'd2, 1'b1);
    run_op(32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0);
    chk_pulse_gone();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports listed in the order below.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 div_start  input  1  one-cycle request from the control unit (driven by DivOp); sampled only in IDLE.
REQ-005 a  input  32  signed dividend (contents of register A); sampled on the accepting edge only.
REQ-006 b  input  32  signed divisor (contents of register B); sampled on the accepting edge only.
REQ-007 hi  output  32  signed remainder; registered, destined for the HI register.
REQ-008 lo  output  32  signed quotient; registered, destined for the LO register.
REQ-009 div_end  output  1  one-cycle completion pulse to the control unit.
REQ-010 div_zero  output  1  one-cycle divide-by-zero flag, coincident with div_end, for exception handling.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have four states: IDLE, CALC, FIX, ZERO.
REQ-013 Accepting edge N (IDLE and div_start=1, b!=0): the block SHALL latch |a| into the dividend shift register and |b| into the divisor register, clear the remainder accumulator, latch neg_q = a[31]^b[31] and neg_r = a[31], set count=0, and go to CALC.
REQ-014 Accepting edge N with b==0: the block SHALL go to ZERO without computing anything.
REQ-015 CALC SHALL perform one restoring-division step per edge: shift {rem,dvd} left by 1, subtract the divisor from the 33-bit partial remainder, and shift in quotient bit 1 (keeping the difference) if it is non-negative, else 0 (restoring the remainder).
REQ-016 CALC SHALL run exactly 32 steps (edges N+1..N+32); count is 6 bits, and the step with count==31 SHALL transition to FIX.
REQ-017 Edge N+33 (FIX): the block SHALL load lo with the two's-complemented quotient if neg_q, else the quotient; load hi with the two's-complemented remainder if neg_r, else the remainder; set div_end=1; return to IDLE.
REQ-018 Edge N+1 (ZERO): the block SHALL set div_end=1 and div_zero=1, leave hi and lo unchanged, and return to IDLE.
REQ-019 div_end and div_zero SHALL be high for exactly one cycle and be cleared on the following edge.
REQ-020 Result semantics SHALL be MIPS DIV: the quotient truncates toward zero, and the remainder takes the sign of the dividend (a = lo*b + hi).
REQ-021 Overflow case 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000, hi=0, with no flag raised.
REQ-022 div_start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-023 hi and lo SHALL hold their values between operations; they change only at the FIX edge or on reset.
REQ-024 A new div_start SHALL be accepted on the edge immediately after the one that returns the FSM to IDLE (back-to-back operation).

Reset
REQ-025 While reset=1, the block SHALL asynchronously force: state=IDLE, hi=0, lo=0, div_end=0, div_zero=0, busy=0, count=0, and all internal registers to 0.
REQ-026 Reset asserted in CALC, FIX or ZERO SHALL abort the operation, with no div_end pulse produced afterward.
REQ-027 After reset deasserts, the block SHALL accept div_start on the first rising edge.

Verification
REQ-028 a=7, b=2, start at edge N -> busy from N, div_end high after N+33, lo=0x00000003, hi=0x00000001, div_zero=0.
REQ-029 a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001.
REQ-030 a=5, b=0 -> div_end=div_zero=1 one cycle after the accepting edge; hi and lo keep their previous values; busy low after that edge.
REQ-031 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_zero=0.
REQ-032 Start 100/7, pulse div_start with a=1, b=1 at N+10 -> result lo=14, hi=2 at N+33; second request ignored.
REQ-033 Start 100/7, assert reset at N+15 for one cycle -> hi=lo=0 immediately, no div_end pulse; a new 9/3 start then yields lo=3, hi=0 after 34 cycles.
